// File: rtl/pc_seq_pkg.sv
// Shared constants and the next-PC source encoding for the program-counter sequencer.
package pc_seq_pkg;

  localparam logic [31:0] RESET_VECTOR_DEF = 32'h0000_0000;
  localparam logic [31:0] EXC_VECTOR_DEF   = 32'h8000_0180;
  localparam int          INSTR_BYTES      = 4;

  typedef enum logic [2:0] {
    SEL_SEQ,
    SEL_BR,
    SEL_J,
    SEL_JR,
    SEL_HOLD,
    SEL_EXC,
    SEL_ERET
  } pc_sel_e;

endpackage

// File: rtl/pc_ras.sv
// Return-address stack: circular buffer with top pointer and occupancy count.
// A push onto a full stack overwrites the oldest entry and sets a sticky flag.
module pc_ras #(
  parameter int XLEN      = 32,
  parameter int RAS_DEPTH = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            push_i,
  input  logic            pop_i,
  input  logic            repl_i,
  input  logic [XLEN-1:0] data_i,
  output logic [XLEN-1:0] top_o,
  output logic            empty_o,
  output logic            ovf_o
);

  localparam int PW = $clog2(RAS_DEPTH);
  localparam int CW = PW + 1;

  logic [PW-1:0]   ptr_q, ptr_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            ovf_q, ovf_d;
  logic [XLEN-1:0] mem_q [RAS_DEPTH];
  logic            wr_en;
  logic [PW-1:0]   wr_idx;
  logic            empty, full;

  assign empty   = (cnt_q == '0);
  assign full    = (cnt_q == CW'(RAS_DEPTH));
  assign empty_o = empty;
  assign ovf_o   = ovf_q;
  assign top_o   = empty ? '0 : mem_q[ptr_q];

  // Next pointer/count/flag and the single write port for push or replace.
  always_comb begin
    ptr_d  = ptr_q;
    cnt_d  = cnt_q;
    ovf_d  = ovf_q;
    wr_en  = 1'b0;
    wr_idx = ptr_q;
    // Replacing the top of an empty stack degenerates to a push.
    if (push_i || (repl_i && empty)) begin
      ptr_d  = ptr_q + PW'(1);
      wr_en  = 1'b1;
      wr_idx = ptr_q + PW'(1);
      if (full) ovf_d = 1'b1;
      else      cnt_d = cnt_q + CW'(1);
    end else if (repl_i) begin
      wr_en  = 1'b1;
      wr_idx = ptr_q;
    end else if (pop_i && !empty) begin
      ptr_d = ptr_q - PW'(1);
      cnt_d = cnt_q - CW'(1);
    end
  end

  // Control state: pointer, count and sticky overflow.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_q <= '0;
      cnt_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      ptr_q <= ptr_d;
      cnt_q <= cnt_d;
      ovf_q <= ovf_d;
    end
  end

  // Entry storage; contents are only observable through a non-zero count.
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_idx] <= data_i;
  end

endmodule

// File: rtl/pc_seq.sv
// Program-counter sequencer: fetch address, exception PC and return-address stack.
module pc_seq
  import pc_seq_pkg::*;
#(
  parameter int              XLEN         = 32,
  parameter logic [XLEN-1:0] RESET_VECTOR = XLEN'(RESET_VECTOR_DEF),
  parameter logic [XLEN-1:0] EXC_VECTOR   = XLEN'(EXC_VECTOR_DEF),
  parameter int              RAS_DEPTH    = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            stall,
  input  logic            branch,
  input  logic [15:0]     imm,
  input  logic            jump,
  input  logic [25:0]     target,
  input  logic            jr,
  input  logic [XLEN-1:0] rs_val,
  input  logic            link,
  input  logic            exc,
  input  logic            eret,
  output logic [XLEN-1:0] pc,
  output logic [XLEN-1:0] pc_plus4,
  output logic [XLEN-1:0] epc,
  output logic [XLEN-1:0] ras_top,
  output logic            ras_empty,
  output logic            ras_ovf,
  output logic            addr_err
);

  logic [XLEN-1:0]        pc_q, pc_d;
  logic [XLEN-1:0]        epc_q, epc_d;
  logic                   aerr_q, aerr_d;
  pc_sel_e                sel;
  logic [XLEN-1:0]        j_addr;
  logic signed [XLEN-1:0] br_off;
  logic                   ras_push, ras_pop, ras_repl;

  assign pc       = pc_q;
  assign epc      = epc_q;
  assign addr_err = aerr_q;
  assign pc_plus4 = pc_q + XLEN'(INSTR_BYTES);
  assign br_off   = {{(XLEN-18){imm[15]}}, imm, 2'b00};

  // Pseudo-direct jumps keep the region bits above bit 27 of the next PC.
  if (XLEN > 28) begin : g_jhi
    assign j_addr = {pc_plus4[XLEN-1:28], target, 2'b00};
  end else begin : g_jlo
    assign j_addr = {target, 2'b00};
  end

  // Priority select of the next PC plus the RAS/EPC side effects of the winner.
  always_comb begin
    sel      = SEL_SEQ;
    pc_d     = pc_plus4;
    epc_d    = epc_q;
    aerr_d   = 1'b0;
    ras_push = 1'b0;
    ras_pop  = 1'b0;
    ras_repl = 1'b0;
    if (exc) begin
      sel   = SEL_EXC;
      pc_d  = EXC_VECTOR;
      epc_d = pc_q;
    end else if (eret) begin
      sel  = SEL_ERET;
      pc_d = epc_q;
    end else if (stall) begin
      sel  = SEL_HOLD;
      pc_d = pc_q;
    end else if (jr) begin
      sel      = SEL_JR;
      pc_d     = {rs_val[XLEN-1:2], 2'b00};
      aerr_d   = (rs_val[1:0] != 2'b00);
      ras_repl = link;
      ras_pop  = !link;
    end else if (jump) begin
      sel      = SEL_J;
      pc_d     = j_addr;
      ras_push = link;
    end else if (branch) begin
      sel  = SEL_BR;
      pc_d = pc_plus4 + $unsigned(br_off);
    end
  end

  // Architectural registers with asynchronous reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_q   <= RESET_VECTOR;
      epc_q  <= '0;
      aerr_q <= 1'b0;
    end else begin
      pc_q   <= pc_d;
      epc_q  <= epc_d;
      aerr_q <= aerr_d;
    end
  end

  pc_ras #(
    .XLEN      (XLEN),
    .RAS_DEPTH (RAS_DEPTH)
  ) u_ras (
    .clk     (clk),
    .rst     (reset),
    .push_i  (ras_push),
    .pop_i   (ras_pop),
    .repl_i  (ras_repl),
    .data_i  (pc_plus4),
    .top_o   (ras_top),
    .empty_o (ras_empty),
    .ovf_o   (ras_ovf)
  );

endmodule

// File: tb/tb_pc_seq.sv
// Self-checking bench for pc_seq: directed scenarios plus randomized traffic
// compared against a queue-based reference model.
module tb_pc_seq;

  logic        clk = 1'b0;
  logic        reset;
  logic        stall, branch, jump, jr, link, exc, eret;
  logic [15:0] imm;
  logic [25:0] target;
  logic [31:0] rs_val;
  logic [31:0] pc, pc_plus4, epc, ras_top;
  logic        ras_empty, ras_ovf, addr_err;

  int checks = 0;
  int errors = 0;

  // reference model state
  logic [31:0] m_pc, m_epc;
  logic [31:0] m_ras[$];
  logic        m_ovf, m_aerr;

  pc_seq dut (
    .clk(clk), .reset(reset), .stall(stall), .branch(branch), .imm(imm),
    .jump(jump), .target(target), .jr(jr), .rs_val(rs_val), .link(link),
    .exc(exc), .eret(eret), .pc(pc), .pc_plus4(pc_plus4), .epc(epc),
    .ras_top(ras_top), .ras_empty(ras_empty), .ras_ovf(ras_ovf),
    .addr_err(addr_err)
  );

  always #5 clk = ~clk;

  task automatic clear_in();
    stall = 0; branch = 0; jump = 0; jr = 0; link = 0; exc = 0; eret = 0;
    imm = '0; target = '0; rs_val = '0;
  endtask

  task automatic model_reset();
    m_pc = 32'h0; m_epc = 32'h0; m_ras.delete(); m_ovf = 0; m_aerr = 0;
  endtask

  // Architectural next-state from the current controls.
  task automatic model_step();
    logic [31:0] p4, npc;
    logic        aerr;
    p4 = m_pc + 32'd4;
    aerr = 0;
    npc = p4;
    if (exc) begin
      npc = 32'h8000_0180;
      m_epc = m_pc;
    end else if (eret) begin
      npc = m_epc;
    end else if (stall) begin
      npc = m_pc;
    end else if (jr) begin
      npc = {rs_val[31:2], 2'b00};
      aerr = (rs_val[1:0] != 0);
      if (link) begin
        if (m_ras.size() == 0) m_ras.push_back(p4);
        else m_ras[m_ras.size()-1] = p4;
      end else if (m_ras.size() > 0) begin
        void'(m_ras.pop_back());
      end
    end else if (jump) begin
      npc = {p4[31:28], target, 2'b00};
      if (link) begin
        if (m_ras.size() == 4) begin
          void'(m_ras.pop_front());
          m_ovf = 1;
        end
        m_ras.push_back(p4);
      end
    end else if (branch) begin
      npc = p4 + ({{16{imm[15]}}, imm} * 32'd4);
    end
    m_pc = npc;
    m_aerr = aerr;
  endtask

  // Apply current controls across one edge, then release them.
  task automatic step();
    model_step();
    @(posedge clk);
    #1;
    clear_in();
  endtask

  task automatic do_reset();
    clear_in();
    reset = 1;
    model_reset();
    repeat (2) @(posedge clk);
    #1 reset = 0;
  endtask

  task automatic test_reset();
    logic [31:0] exp_seq [3];
    exp_seq[0] = 32'h4; exp_seq[1] = 32'h8; exp_seq[2] = 32'hC;
    do_reset();
    checks++; if (pc !== 32'h0) begin errors++; $display("FAIL reset_pc: got %h expected %h", pc, 32'h0); end
    checks++; if (epc !== 32'h0) begin errors++; $display("FAIL reset_epc: got %h expected %h", epc, 32'h0); end
    checks++; if (ras_empty !== 1'b1 || ras_top !== 32'h0) begin errors++; $display("FAIL reset_ras: got empty=%b top=%h expected empty=1 top=0", ras_empty, ras_top); end
    checks++; if (ras_ovf !== 1'b0 || addr_err !== 1'b0) begin errors++; $display("FAIL reset_flags: got ovf=%b aerr=%b expected 0 0", ras_ovf, addr_err); end
    for (int i = 0; i < 3; i++) begin
      step();
      checks++; if (pc !== exp_seq[i]) begin errors++; $display("FAIL seq_pc%0d: got %h expected %h", i, pc, exp_seq[i]); end
    end
    // asynchronous reset in the middle of a cycle
    #2 reset = 1;
    #1;
    checks++; if (pc !== 32'h0) begin errors++; $display("FAIL async_reset_pc: got %h expected %h", pc, 32'h0); end
    model_reset();
    @(posedge clk);
    #1 reset = 0;
    step();
    checks++; if (pc !== 32'h4) begin errors++; $display("FAIL post_reset_pc: got %h expected %h", pc, 32'h4); end
  endtask

  task automatic test_branch_stall();
    do_reset();
    repeat (4) step();
    checks++; if (pc !== 32'h10) begin errors++; $display("FAIL br_setup_pc: got %h expected %h", pc, 32'h10); end
    branch = 1; imm = 16'hFFFE;
    step();
    checks++; if (pc !== 32'h0C) begin errors++; $display("FAIL branch_neg: got %h expected %h", pc, 32'h0C); end
    stall = 1; branch = 1; imm = 16'h0040;
    step();
    checks++; if (pc !== 32'h0C) begin errors++; $display("FAIL stall_hold: got %h expected %h", pc, 32'h0C); end
    branch = 1; imm = 16'h0003;
    step();
    checks++; if (pc !== 32'h1C) begin errors++; $display("FAIL branch_pos: got %h expected %h", pc, 32'h1C); end
  endtask

  task automatic test_jump_link_jr();
    jr = 1; rs_val = 32'hF000_0008;
    step();
    checks++; if (pc !== 32'hF000_0008) begin errors++; $display("FAIL jr_setup_pc: got %h expected %h", pc, 32'hF000_0008); end
    jump = 1; link = 1; target = 26'h000020;
    step();
    checks++; if (pc !== 32'hF000_0080) begin errors++; $display("FAIL jal_pc: got %h expected %h", pc, 32'hF000_0080); end
    checks++; if (ras_top !== 32'hF000_000C || ras_empty !== 1'b0) begin errors++; $display("FAIL jal_ras: got top=%h empty=%b expected top=%h empty=0", ras_top, ras_empty, 32'hF000_000C); end
    jr = 1; rs_val = 32'hF000_000D;
    step();
    checks++; if (pc !== 32'hF000_000C) begin errors++; $display("FAIL jr_ret_pc: got %h expected %h", pc, 32'hF000_000C); end
    checks++; if (addr_err !== 1'b1) begin errors++; $display("FAIL jr_addr_err: got %b expected 1", addr_err); end
    checks++; if (ras_empty !== 1'b1) begin errors++; $display("FAIL jr_pop_empty: got %b expected 1", ras_empty); end
    step();
    checks++; if (addr_err !== 1'b0) begin errors++; $display("FAIL addr_err_pulse: got %b expected 0", addr_err); end
  endtask

  task automatic test_ras_overflow();
    logic [31:0] links [5];
    do_reset();
    for (int i = 0; i < 5; i++) begin
      links[i] = m_pc + 32'd4;
      jump = 1; link = 1; target = 26'($urandom);
      step();
      if (i == 3) begin
        checks++; if (ras_ovf !== 1'b0) begin errors++; $display("FAIL ovf_early: got %b expected 0", ras_ovf); end
      end
    end
    checks++; if (ras_ovf !== 1'b1) begin errors++; $display("FAIL ovf_set: got %b expected 1", ras_ovf); end
    for (int i = 0; i < 4; i++) begin
      checks++; if (ras_top !== links[4-i]) begin errors++; $display("FAIL ras_pop%0d: got %h expected %h", i, ras_top, links[4-i]); end
      jr = 1; rs_val = {$urandom} & 32'hFFFF_FFFC;
      step();
    end
    checks++; if (ras_empty !== 1'b1 || ras_top !== 32'h0) begin errors++; $display("FAIL ras_drained: got empty=%b top=%h expected empty=1 top=0", ras_empty, ras_top); end
    checks++; if (ras_ovf !== 1'b1) begin errors++; $display("FAIL ovf_sticky: got %b expected 1", ras_ovf); end
  endtask

  task automatic test_exc_eret();
    jr = 1; rs_val = 32'h40;
    step();
    checks++; if (pc !== 32'h40) begin errors++; $display("FAIL exc_setup_pc: got %h expected %h", pc, 32'h40); end
    exc = 1; eret = 1; jump = 1; link = 1;
    step();
    checks++; if (pc !== 32'h8000_0180 || epc !== 32'h40) begin errors++; $display("FAIL exc_entry: got pc=%h epc=%h expected pc=%h epc=%h", pc, epc, 32'h8000_0180, 32'h40); end
    checks++; if (ras_empty !== 1'b1) begin errors++; $display("FAIL exc_no_push: got %b expected 1", ras_empty); end
    eret = 1;
    step();
    checks++; if (pc !== 32'h40) begin errors++; $display("FAIL eret_pc: got %h expected %h", pc, 32'h40); end
  endtask

  task automatic test_wrap();
    jr = 1; rs_val = 32'hFFFF_FFFC;
    step();
    checks++; if (pc_plus4 !== 32'h0) begin errors++; $display("FAIL wrap_plus4: got %h expected %h", pc_plus4, 32'h0); end
    step();
    checks++; if (pc !== 32'h0) begin errors++; $display("FAIL wrap_pc: got %h expected %h", pc, 32'h0); end
  endtask

  task automatic test_random();
    logic [31:0] exp_top;
    do_reset();
    for (int n = 0; n < 400; n++) begin
      exc    = ($urandom_range(99) < 2);
      eret   = ($urandom_range(99) < 3);
      stall  = ($urandom_range(99) < 10);
      jr     = ($urandom_range(99) < 15);
      jump   = ($urandom_range(99) < 20);
      branch = ($urandom_range(99) < 25);
      link   = ($urandom_range(99) < 50);
      imm    = 16'($urandom);
      target = 26'($urandom);
      rs_val = $urandom;
      step();
      exp_top = (m_ras.size() == 0) ? 32'h0 : m_ras[m_ras.size()-1];
      checks++;
      if (pc !== m_pc || pc_plus4 !== m_pc + 32'd4 || epc !== m_epc || ras_top !== exp_top ||
          ras_empty !== (m_ras.size() == 0) || ras_ovf !== m_ovf || addr_err !== m_aerr) begin
        errors++;
        $display("FAIL random_cycle%0d: got pc=%h p4=%h epc=%h top=%h emp=%b ovf=%b aerr=%b expected pc=%h epc=%h top=%h emp=%b ovf=%b aerr=%b",
                 n, pc, pc_plus4, epc, ras_top, ras_empty, ras_ovf, addr_err,
                 m_pc, m_epc, exp_top, (m_ras.size() == 0), m_ovf, m_aerr);
      end
    end
  endtask

  initial begin
    reset = 1;
    clear_in();
    model_reset();
    test_reset();
    test_branch_stall();
    test_jump_link_jr();
    test_ras_overflow();
    test_exc_eret();
    test_wrap();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pc_seq.md
# pc_seq

Parametrised program-counter sequencer for the MIPS core, the successor to the single-cycle `pc` register. It owns the fetch address and computes the next PC for:
- sequential flow, conditional branch, pseudo-direct jump and register jump;
- exception entry and exception return;
- stall.

It also maintains a small return-address stack (RAS) that link instructions push and register jumps pop. The fetch stage consumes the RAS top as a return prediction.

## Interface
Parameters:
- `XLEN`, 32, address width (≥ 28)
- `RESET_VECTOR`, 32'h0000_0000, PC value on reset
- `EXC_VECTOR`, 32'h8000_0180, exception entry address
- `RAS_DEPTH`, 4, return-address stack entries (power of two, ≥ 2)

Ports:
- `clk`  in  1  sole clock; all state updates on rising edge
- `reset`  in  1  asynchronous, active-high reset
- `stall`  in  1  hold PC, EPC and RAS unchanged
- `branch`  in  1  taken conditional branch
- `imm`  in  16  branch offset in words, signed
- `jump`  in  1  pseudo-direct jump
- `target`  in  26  jump word index
- `jr`  in  1  register jump
- `rs_val`  in  XLEN  register-jump target
- `link`  in  1  with `jump` or `jr`: push return address `pc_plus4`
- `exc`  in  1  take exception
- `eret`  in  1  return from exception
- `pc`  out  XLEN  current fetch address (registered)
- `pc_plus4`  out  XLEN  `pc + 4` (combinational)
- `epc`  out  XLEN  exception PC (registered)
- `ras_top`  out  XLEN  top RAS entry; 0 when empty
- `ras_empty`  out  1  RAS holds no entries
- `ras_ovf`  out  1  sticky: a push overwrote the oldest entry
- `addr_err`  out  1  registered one-cycle pulse: misaligned `jr` target

## Operation
- Next-PC priority, highest first:
  - `exc`: `EXC_VECTOR`; `epc <= pc`
  - `eret`: `epc`
  - `stall`: `pc`
  - `jr`: `{rs_val[XLEN-1:2], 2'b00}`
  - `jump`: `{pc_plus4[XLEN-1:28], target, 2'b00}`
  - `branch`: `pc_plus4 + (sext(imm) << 2)`
  - none of the above: `pc_plus4`
- All arithmetic is modulo 2^XLEN. Increment wraps from `2^XLEN-4` to 0; a negative branch offset may wrap below 0.
- `addr_err` is 1 for the cycle after an accepted `jr` with `rs_val[1:0] != 0`; 0 otherwise. PC still takes the aligned target.
- RAS is a circular buffer with a pointer and a count.
  - Push: accepted `link` with `jump`. Writes `pc_plus4` at the top.
  - Pop: accepted `jr` with `link=0` and RAS non-empty. Count decrements.
  - `jr` with `link=1`: the top entry is replaced by `pc_plus4`; count is unchanged. If the RAS is empty, this is a plain push.
  - Push when full: overwrite the oldest entry, count stays `RAS_DEPTH`, set `ras_ovf`.
  - Pop when empty: no RAS change; PC still redirects.
  - `link` without `jump` or `jr`: ignored.
- "Accepted" means the redirect won the priority above. `exc`, `eret` and `stall` suppress every RAS and EPC-neutral action in that cycle.
- `exc` and `eret` together: `exc` wins and EPC captures the current `pc`.

## Timing
- Reset values (asynchronous, applied immediately on `reset`):
  - `pc = RESET_VECTOR`, `epc = 0`
  - RAS count 0, `ras_empty = 1`, `ras_top = 0`
  - `ras_ovf = 0`, `addr_err = 0`
- Redirect latency is one cycle: controls sampled at edge N drive `pc` after edge N.
- `pc_plus4` and `ras_top` are combinational from registered state; they have no input-to-output path.
- Reset asserted mid-stall or mid-redirect discards the pending update. The first post-reset edge advances to `RESET_VECTOR+4` unless a control input is active.

## Structure
- Shared package `pc_seq_pkg`:
  - default vector constants;
  - `pc_sel_e` enum: `SEL_SEQ`, `SEL_BR`, `SEL_J`, `SEL_JR`, `SEL_HOLD`, `SEL_EXC`, `SEL_ERET`;
  - `INSTR_BYTES = 4`.
- One sub-module, `pc_ras`: parametrised by `XLEN` and `RAS_DEPTH`, with push/pop/replace inputs and top/empty/ovf outputs.
- Next-PC select logic stays in `pc_seq`.

## Test plan
- Reset then 3 idle cycles → `pc` reads 0, 4, 8, C.
  - Assert `reset` mid-cycle → `pc = 0` immediately.
- `pc = 0x10`, `branch=1`, `imm=16'hFFFE` → `pc = 0x0C`.
  - `stall=1` with `branch=1` → `pc` holds at 0x0C.
- `pc = 0xF000_0008`, `jump=1`, `link=1`, `target=26'h000020` → `pc = 0xF000_0080`, `ras_top = 0xF000_000C`.
  - Then `jr=1`, `rs_val = 0xF000_000D` → `pc = 0xF000_000C`, `addr_err = 1` for one cycle, `ras_empty = 1`.
- 5 linked jumps with `RAS_DEPTH=4` → `ras_ovf = 1`.
  - 4 pops then return the last 4 link addresses in reverse order; then `ras_empty = 1`.
- `pc = 0x40`, `exc=1` and `eret=1` together → `pc = 0x8000_0180`, `epc = 0x40`.
  - Next `eret` → `pc = 0x40`.
- Increment at `pc = 0xFFFF_FFFC` → `pc = 0`.
